// File: rtl/sobel_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_window_gen
//  Purpose  : Raster-to-window front end for the Sobel edge core. Accepts one
//             8-bit pixel per valid cycle in row-major order, keeps two line
//             buffers and a 3x3 shift window, and emits one window plus a
//             one-cycle core enable for every interior pixel position.
//  Ports    : clk, rst_n (async, active-low)
//             start_i             frame start pulse (honoured only in IDLE)
//             pixel_i/pixel_en_i  raster pixel stream
//             data_R_C_o          3x3 window, R = row (0 oldest line),
//                                 C = column (0 oldest column)
//             core_en_o           window valid pulse
//             busy_o              frame in progress
//             done_o              pulse in the cycle after the last pixel
//  Revision : 1.0  initial release
// ============================================================================
module sobel_window_gen #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] pixel_i,
  input  logic       pixel_en_i,
  output logic [7:0] data_0_0_o,
  output logic [7:0] data_0_1_o,
  output logic [7:0] data_0_2_o,
  output logic [7:0] data_1_0_o,
  output logic [7:0] data_1_1_o,
  output logic [7:0] data_1_2_o,
  output logic [7:0] data_2_0_o,
  output logic [7:0] data_2_1_o,
  output logic [7:0] data_2_2_o,
  output logic       core_en_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [7:0]       win_q [3][3];
  logic [7:0]       win_d [3][3];
  logic             core_en_q, core_en_d;
  logic             done_q, done_d;

  // Line buffers: lb0 holds the previous line, lb1 the line before that.
  // Never reset; every entry is rewritten before a window uses it.
  logic [7:0]       lb0_q [IMG_W];
  logic [7:0]       lb1_q [IMG_W];

  logic             accept;
  logic [7:0]       lb_top;
  logic [7:0]       lb_mid;

  assign accept = (state_q == ACTIVE) && pixel_en_i;
  assign lb_top = lb1_q[col_q];
  assign lb_mid = lb0_q[col_q];

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    win_d     = win_q;
    core_en_d = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ACTIVE;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ACTIVE: begin
        if (pixel_en_i) begin
          // Shift the window left by one column and load the new column
          // {row-2, row-1, row} at the right edge.
          for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
              win_d[r][c] = win_q[r][c+1];
            end
          end
          win_d[0][2] = lb_top;
          win_d[1][2] = lb_mid;
          win_d[2][2] = pixel_i;

          // The first two columns of each row only flush stale columns.
          core_en_d = (row_q >= ROW_TWO) && (col_q >= COL_TWO);

          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              row_d = row_q + ROW_ONE;
            end
          end else begin
            col_d = col_q + COL_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      core_en_q <= 1'b0;
      done_q    <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= 8'd0;
        end
      end
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      core_en_q <= core_en_d;
      done_q    <= done_d;
      win_q     <= win_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= pixel_i;
    end
  end

  assign data_0_0_o = win_q[0][0];
  assign data_0_1_o = win_q[0][1];
  assign data_0_2_o = win_q[0][2];
  assign data_1_0_o = win_q[1][0];
  assign data_1_1_o = win_q[1][1];
  assign data_1_2_o = win_q[1][2];
  assign data_2_0_o = win_q[2][0];
  assign data_2_1_o = win_q[2][1];
  assign data_2_2_o = win_q[2][2];

  assign core_en_o = core_en_q;
  assign busy_o    = (state_q == ACTIVE);
  assign done_o    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sobel_window_gen
//  Purpose  : Self-checking bench for sobel_window_gen. A reference model of
//             the frame (image array indexed by row/col) produces the
//             expected 3x3 window for each interior pixel; these are queued
//             when the pixel is driven and compared when core_en_o fires.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sobel_window_gen;

  localparam int W = 5;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] pixel_i = 8'd0;
  logic       pixel_en_i = 1'b0;
  logic [7:0] d00, d01, d02, d10, d11, d12, d20, d21, d22;
  logic       core_en_o, busy_o, done_o;

  // 3x3 instance for the minimum-size frame
  logic       b_start = 1'b0;
  logic [7:0] b_pix = 8'd0;
  logic       b_en = 1'b0;
  logic [7:0] b00, b01, b02, b10, b11, b12, b20, b21, b22;
  logic       b_core_en, b_busy, b_done;

  always #5 clk = ~clk;

  sobel_window_gen #(.IMG_W(W), .IMG_H(H)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .pixel_i(pixel_i),
    .pixel_en_i(pixel_en_i),
    .data_0_0_o(d00), .data_0_1_o(d01), .data_0_2_o(d02),
    .data_1_0_o(d10), .data_1_1_o(d11), .data_1_2_o(d12),
    .data_2_0_o(d20), .data_2_1_o(d21), .data_2_2_o(d22),
    .core_en_o(core_en_o), .busy_o(busy_o), .done_o(done_o)
  );

  sobel_window_gen #(.IMG_W(3), .IMG_H(3)) u_dut_min (
    .clk(clk), .rst_n(rst_n), .start_i(b_start), .pixel_i(b_pix),
    .pixel_en_i(b_en),
    .data_0_0_o(b00), .data_0_1_o(b01), .data_0_2_o(b02),
    .data_1_0_o(b10), .data_1_1_o(b11), .data_1_2_o(b12),
    .data_2_0_o(b20), .data_2_1_o(b21), .data_2_2_o(b22),
    .core_en_o(b_core_en), .busy_o(b_busy), .done_o(b_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic        m_active = 1'b0;
  int          m_row = 0;
  int          m_col = 0;
  int          img [H][W];
  logic [71:0] sb [$];
  logic [71:0] prev_win = '0;
  logic [71:0] first_win = '0;
  logic [71:0] last_win = '0;
  int          n_pulse = 0;
  int          n_done = 0;

  task automatic check_eq(input string tag, input logic [71:0] got,
                          input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] dut_win();
    return {d00, d01, d02, d10, d11, d12, d20, d21, d22};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_win"}, dut_win(), 72'd0);
    check_eq({tag, "_core_en"}, core_en_o, 1'b0);
    check_eq({tag, "_busy"}, busy_o, 1'b0);
    check_eq({tag, "_done"}, done_o, 1'b0);
  endtask

  // One clock cycle: drive inputs, predict, sample #1 after the edge, compare.
  task automatic step(input logic s, input logic en, input logic [7:0] p);
    logic        acc, exp_en, exp_done;
    logic [71:0] ew, ow;
    start_i    = s;
    pixel_en_i = en;
    pixel_i    = p;
    acc      = m_active && en;
    exp_en   = 1'b0;
    exp_done = 1'b0;
    ew       = '0;
    if (acc) begin
      img[m_row][m_col] = int'(p);
      if (m_row >= 2 && m_col >= 2) begin
        exp_en = 1'b1;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            ew = {ew[63:0], 8'(img[m_row-2+i][m_col-2+j])};
        sb.push_back(ew);
      end
      exp_done = (m_row == H-1) && (m_col == W-1);
    end
    @(posedge clk);
    #1;
    ow = dut_win();
    check_eq("core_en", core_en_o, exp_en);
    check_eq("done", done_o, exp_done);
    if (done_o) n_done++;
    if (core_en_o) begin
      check_eq("sb_avail", sb.size(), 1);
      if (sb.size() > 0) begin
        ew = sb.pop_front();
        check_eq("window", ow, ew);
        if (n_pulse == 0) first_win = ow;
        last_win = ow;
        n_pulse++;
      end
    end
    sb.delete();
    if (!acc) check_eq("hold", ow, prev_win);
    prev_win = ow;
    if (!m_active) begin
      if (s) begin
        m_active = 1'b1;
        m_row = 0;
        m_col = 0;
      end
    end else if (en) begin
      if (m_row == H-1 && m_col == W-1) m_active = 1'b0;
      else if (m_col == W-1) begin
        m_col = 0;
        m_row++;
      end else m_col++;
    end
    check_eq("busy", busy_o, m_active);
  endtask

  task automatic run_frame(input int base, input logic gaps, input logic noise);
    n_pulse = 0;
    n_done  = 0;
    if (noise) begin
      step(1'b0, 1'b1, 8'd99);
      step(1'b0, 1'b1, 8'd98);
      step(1'b1, 1'b1, 8'd77);
    end else begin
      step(1'b1, 1'b0, 8'd0);
    end
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (gaps) repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 8'hAA);
        step(noise && r == 1 && c == 2, 1'b1, 8'(base + 10*r + c));
      end
    end
    check_eq("pulse_count", n_pulse, (W-2)*(H-2));
    check_eq("done_count", n_done, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    logic [71:0] exp_first;
    int          bp, bd;
    exp_first = {8'd0, 8'd1, 8'd2, 8'd10, 8'd11, 8'd12, 8'd20, 8'd21, 8'd22};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // basic frame
    idle(2);
    run_frame(0, 1'b0, 1'b0);
    check_eq("first_win", first_win, exp_first);
    check_eq("last_d00", last_win[71:64], 8'd12);
    check_eq("last_d22", last_win[7:0], 8'd34);
    idle(3);

    // gapped input
    run_frame(0, 1'b1, 1'b0);
    check_eq("gap_first_win", first_win, exp_first);
    idle(3);

    // idle/ignore rules
    run_frame(0, 1'b0, 1'b1);
    check_eq("ign_first_win", first_win, exp_first);
    idle(3);

    // reset mid-frame after 13 accepted pixels
    step(1'b1, 1'b0, 8'd0);
    for (int k = 0; k < 13; k++) step(1'b0, 1'b1, 8'(10*(k/W) + (k%W)));
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midrst");
    m_active = 1'b0;
    sb.delete();
    prev_win = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    run_frame(0, 1'b0, 1'b0);
    check_eq("rst_first_win", first_win, exp_first);
    idle(3);

    // back-to-back frames: second start lands in the done cycle
    run_frame(0, 1'b0, 1'b0);
    run_frame(100, 1'b0, 1'b0);
    check_eq("b2b_d00", first_win[71:64], 8'd100);
    check_eq("b2b_d22", first_win[7:0], 8'd122);
    idle(3);

    // minimum 3x3 frame
    bp = 0;
    bd = 0;
    b_start = 1'b1;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      b_en  = (i < 9);
      b_pix = 8'(10*(i/3) + (i%3));
      @(posedge clk);
      #1;
      if (b_core_en) begin
        bp++;
        check_eq("min_d11", b11, 8'd11);
        check_eq("min_done_with_en", b_done, 1'b1);
      end
      if (b_done) bd++;
    end
    b_en = 1'b0;
    check_eq("min_pulses", bp, 1);
    check_eq("min_dones", bd, 1);
    check_eq("min_busy_end", b_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
